// File: rtl/johnson_decoder_monitor.sv
// Johnson code decoder and sequence monitor.
// Decodes an N-stage twisted-ring code to its index 0..2N-1. It also checks
// that the code is legal and that it advances by one step per valid sample.
// A lock FSM gains lock after LOCK_CNT in-sequence steps, and errors seen
// while locked are counted.
module johnson_decoder_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  localparam int IW      = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  jc_in,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [N-1:0] ALL1 = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic            have_prev_q, have_prev_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            idx_valid_q, idx_valid_d;
  logic            illegal_q, illegal_d;
  logic            seq_err_q, seq_err_d;
  logic [7:0]      err_count_q, err_count_d;

  // Compare the input against every legal code of the ring. Code k has k low
  // ones for k < N, and ones from bit k-N upward for k >= N. At most one
  // code can match.
  logic [2*N-1:0]  match;
  genvar gi;
  generate
    for (gi = 0; gi < 2*N; gi++) begin : g_pat
      localparam logic [N-1:0] PAT = (gi < N) ? (ALL1 >> (N - gi)) : (ALL1 << (gi - N));
      assign match[gi] = (jc_in == PAT);
    end
  endgenerate

  logic            legal;
  logic [IW-1:0]   dec_idx;
  logic [IW-1:0]   next_exp;
  logic            in_seq;

  // Encode the one-hot match vector into the decoded index.
  always_comb begin
    dec_idx = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (match[k]) dec_idx = IW'(k);
    end
  end

  assign legal    = |match;
  // idx_q always holds the last legal index, so it is the previous index
  // for the sequence check. Step 2N-1 wraps to 0.
  assign next_exp = (idx_q == IW'(2*N - 1)) ? '0 : idx_q + 1'b1;
  assign in_seq   = have_prev_q && (dec_idx == next_exp);

  // Next-state logic: lock FSM, decoded-index capture, pulses, error counter.
  always_comb begin
    logic err_inc;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    have_prev_d = have_prev_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;
    err_inc     = 1'b0;

    if (in_valid) begin
      if (legal) begin
        idx_d       = dec_idx;
        idx_valid_d = 1'b1;
        have_prev_d = 1'b1;
        case (state_q)
          UNLOCKED: begin
            state_d    = LOCKING;
            good_cnt_d = '0;
          end
          LOCKING: begin
            if (in_seq) begin
              if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
                state_d    = LOCKED;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_cnt_q + 1'b1;
              end
            end else begin
              seq_err_d  = 1'b1;
              good_cnt_d = '0;
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              seq_err_d  = 1'b1;
              err_inc    = 1'b1;
              state_d    = LOCKING;
              good_cnt_d = '0;
            end
          end
          default: begin
            state_d    = UNLOCKED;
            good_cnt_d = '0;
          end
        endcase
      end else begin
        // An illegal code breaks the chain. idx keeps the last good value.
        illegal_d   = 1'b1;
        have_prev_d = 1'b0;
        err_inc     = (state_q == LOCKED);
        state_d     = UNLOCKED;
        good_cnt_d  = '0;
      end
    end

    if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      good_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      have_prev_q <= have_prev_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Scoreboard bench for johnson_decoder_monitor (N=4, LOCK_CNT=2).
// The driver applies one vector per cycle and pushes the hand-computed
// response. The monitor pops one expectation after each rising edge.
module tb_johnson_decoder_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] jc_in = 4'b0000;
  logic [2:0] idx;
  logic       idx_valid, illegal, seq_err, locked;
  logic [7:0] err_count;

  johnson_decoder_monitor #(.N(4), .LOCK_CNT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .jc_in(jc_in),
    .idx(idx), .idx_valid(idx_valid), .illegal(illegal), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] idx;
    logic       iv, ill, se, lk;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // The Johnson sequence for N=4, in index order.
  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  task automatic step(input string name, input logic rst, input logic v, input logic [3:0] code,
                      input logic [2:0] e_idx, input logic e_iv, input logic e_ill,
                      input logic e_se, input logic e_lk, input logic [7:0] e_ec);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    jc_in    = code;
    e.name = name; e.idx = e_idx; e.iv = e_iv; e.ill = e_ill;
    e.se = e_se; e.lk = e_lk; e.ec = e_ec;
    q.push_back(e);
  endtask

  // Monitor: compares the registered outputs after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (idx !== e.idx || idx_valid !== e.iv || illegal !== e.ill ||
            seq_err !== e.se || locked !== e.lk || err_count !== e.ec) begin
          miscompares++;
          $display("FAIL %s: got idx=%0d iv=%b ill=%b se=%b lk=%b ec=%0d, want idx=%0d iv=%b ill=%b se=%b lk=%b ec=%0d",
                   e.name, idx, idx_valid, illegal, seq_err, locked, err_count,
                   e.idx, e.iv, e.ill, e.se, e.lk, e.ec);
        end else begin
          $display("ok   %s: idx=%0d iv=%b ill=%b se=%b lk=%b ec=%0d",
                   e.name, idx, idx_valid, illegal, seq_err, locked, err_count);
        end
      end
    end
  end

  initial begin
    int a;
    int ec;
    // Reset state
    step("reset", 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    // An illegal code while unlocked is flagged but not counted
    step("unl_illegal", 0, 1, 4'b1010, 0, 0, 1, 0, 0, 0);
    // Test 1: acquire lock
    step("t1_0000", 0, 1, 4'b0000, 0, 1, 0, 0, 0, 0);
    step("t1_0001", 0, 1, 4'b0001, 1, 1, 0, 0, 0, 0);
    step("t1_0011", 0, 1, 4'b0011, 2, 1, 0, 0, 1, 0);
    // Test 2: full cycle including the 7->0 wrap
    step("t2_0111", 0, 1, 4'b0111, 3, 1, 0, 0, 1, 0);
    step("t2_1111", 0, 1, 4'b1111, 4, 1, 0, 0, 1, 0);
    step("t2_1110", 0, 1, 4'b1110, 5, 1, 0, 0, 1, 0);
    step("t2_1100", 0, 1, 4'b1100, 6, 1, 0, 0, 1, 0);
    step("t2_1000", 0, 1, 4'b1000, 7, 1, 0, 0, 1, 0);
    step("t2_wrap0000", 0, 1, 4'b0000, 0, 1, 0, 0, 1, 0);
    step("t2_0001", 0, 1, 4'b0001, 1, 1, 0, 0, 1, 0);
    step("t2_0011", 0, 1, 4'b0011, 2, 1, 0, 0, 1, 0);
    // Test 3: illegal code while locked, then relock
    step("t3_illegal0101", 0, 1, 4'b0101, 2, 0, 1, 0, 0, 1);
    step("t3_0011", 0, 1, 4'b0011, 2, 1, 0, 0, 0, 1);
    step("t3_0111", 0, 1, 4'b0111, 3, 1, 0, 0, 0, 1);
    step("t3_1111_relock", 0, 1, 4'b1111, 4, 1, 0, 0, 1, 1);
    step("t3_1110", 0, 1, 4'b1110, 5, 1, 0, 0, 1, 1);
    step("t3_1100", 0, 1, 4'b1100, 6, 1, 0, 0, 1, 1);
    step("t3_1000", 0, 1, 4'b1000, 7, 1, 0, 0, 1, 1);
    step("t3_0000", 0, 1, 4'b0000, 0, 1, 0, 0, 1, 1);
    step("t3_0001", 0, 1, 4'b0001, 1, 1, 0, 0, 1, 1);
    step("t3_0011", 0, 1, 4'b0011, 2, 1, 0, 0, 1, 1);
    // Test 4: skipped step (2 -> 4) while locked
    step("t4_skip1111", 0, 1, 4'b1111, 4, 1, 0, 1, 0, 2);
    step("t4_1110", 0, 1, 4'b1110, 5, 1, 0, 0, 0, 2);
    step("t4_1100_relock", 0, 1, 4'b1100, 6, 1, 0, 0, 1, 2);
    // Test 5: break the lock, then insert valid=0 gaps while relocking
    step("t5_illegal", 0, 1, 4'b1011, 6, 0, 1, 0, 0, 3);
    step("t5_0000", 0, 1, 4'b0000, 0, 1, 0, 0, 0, 3);
    step("t5_0001", 0, 1, 4'b0001, 1, 1, 0, 0, 0, 3);
    step("t5_gap0", 0, 0, 4'b0101, 1, 0, 0, 0, 0, 3);
    step("t5_gap1", 0, 0, 4'b1111, 1, 0, 0, 0, 0, 3);
    step("t5_gap2", 0, 0, 4'b1010, 1, 0, 0, 0, 0, 3);
    step("t5_0011_lock", 0, 1, 4'b0011, 2, 1, 0, 0, 1, 3);
    // Test 6: 300 repeated-code errors, each followed by a relock
    a  = 2;
    ec = 3;
    for (int k = 0; k < 300; k++) begin
      ec = (ec < 255) ? ec + 1 : 255;
      step($sformatf("t6_rep%0d", k), 0, 1, codes[a], 3'(a), 1, 0, 1, 0, 8'(ec));
      step($sformatf("t6_a%0d", k), 0, 1, codes[(a+1)%8], 3'((a+1)%8), 1, 0, 0, 0, 8'(ec));
      step($sformatf("t6_b%0d", k), 0, 1, codes[(a+2)%8], 3'((a+2)%8), 1, 0, 0, 1, 8'(ec));
      a = (a + 2) % 8;
    end
    // Reset wins over a simultaneous valid sample
    step("t6_reset_with_valid", 1, 1, codes[(a+1)%8], 0, 0, 0, 0, 0, 0);
    step("post_reset_idle", 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    step("post_reset_first", 0, 1, 4'b0011, 2, 1, 0, 0, 0, 0);

    // Wait, with a bound, for the monitor to drain the scoreboard.
    for (int c = 0; c < 10 && q.size() > 0; c++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
